// File: rtl/pipeline_forward_ctrl_pkg.sv
// Shared types and constants for the EX-stage operand-forwarding controller.
package pipeline_forward_ctrl_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } stage_rec_t;

  function automatic logic produces(stage_rec_t rec, logic [REG_AW-1:0] r,
                                    logic [REG_AW-1:0] zero);
    return rec.valid & rec.regwrite & (rec.dst == r) & (r != zero);
  endfunction

  // Saturating add used by the optional statistics counters.
  function automatic logic [31:0] sat_add(logic [31:0] v, logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, v} + {31'b0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/pipeline_forward_ctrl_if.sv
// ID-stage inputs and forwarding/hazard outputs of the forwarding controller.
// Counter signals exist only when FWD_STATS_EN is defined.
interface pipeline_forward_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic              ID_Valid;
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic              ID_UseRs;
  logic              ID_UseRt;
  logic [REG_AW-1:0] ID_Dst;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              EX_BranchTaken;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic              Stall;
  logic              IDEX_Bubble;
  logic              IFID_Flush;
`ifdef FWD_STATS_EN
  logic [31:0]       StallCnt;
  logic [31:0]       FwdExMemCnt;
  logic [31:0]       FwdMemWbCnt;
`endif

  // master: the controller; slave: the pipeline that consumes its selects.
  modport master (
    output ForwardA, ForwardB, Stall, IDEX_Bubble, IFID_Flush,
`ifdef FWD_STATS_EN
    output StallCnt, FwdExMemCnt, FwdMemWbCnt,
`endif
    input  ID_Valid, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Dst, ID_RegWrite, ID_MemRead,
    input  EX_BranchTaken
  );

  modport slave (
    input  ForwardA, ForwardB, Stall, IDEX_Bubble, IFID_Flush,
`ifdef FWD_STATS_EN
    input  StallCnt, FwdExMemCnt, FwdMemWbCnt,
`endif
    output ID_Valid, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Dst, ID_RegWrite, ID_MemRead,
    output EX_BranchTaken
  );
endinterface

// File: rtl/pipeline_forward_ctrl_fwd_select.sv
// Per-operand forwarding select: the youngest in-flight producer of the source wins.
module fwd_select
  import pipeline_forward_ctrl_pkg::*;
#(
  parameter logic [REG_AW-1:0] ZeroReg = '0
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  stage_rec_t        ex_rec,
  input  stage_rec_t        mem_rec,
  output logic [1:0]        sel
);
  // Load-ness is irrelevant here; load-use is resolved by the stall logic.
  logic unused_memread;
  assign unused_memread = ex_rec.memread ^ mem_rec.memread;

  always_comb begin
    sel = FWD_REG;
    if (use_src && produces(ex_rec, src, ZeroReg)) begin
      sel = FWD_EXMEM;
    end else if (use_src && produces(mem_rec, src, ZeroReg)) begin
      sel = FWD_MEMWB;
    end
  end
endmodule

// File: rtl/pipeline_forward_ctrl.sv
// Forwarding/hazard controller: tracks EX/MEM/WB destination records, registers operand
// selects one cycle ahead, and raises load-use stalls and branch flushes. Macro: FWD_STATS_EN.
module pipeline_forward_ctrl #(
  parameter int unsigned       REG_AW   = 5,
  parameter logic [REG_AW-1:0] ZERO_REG = '0
) (
  input logic                     clk,
  input logic                     reset,
  pipeline_forward_ctrl_if.master bus
);
  import pipeline_forward_ctrl_pkg::*;

  stage_rec_t        ex_q, mem_q, wb_q, id_rec;
  logic [REG_AW-1:0] ex_dst;
  logic              lu, flush, bubble, stall;
  logic [1:0]        sel_a, sel_b, fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  logic              unused_wb;

  always_comb begin
    id_rec = '{valid: bus.ID_Valid, dst: bus.ID_Dst, regwrite: bus.ID_RegWrite,
               memread: bus.ID_MemRead};
    ex_dst = ex_q.dst;
    lu = bus.ID_Valid & ex_q.valid & ex_q.memread & ex_q.regwrite & (ex_dst != ZERO_REG) &
         ((bus.ID_UseRs & (bus.ID_Rs == ex_dst)) | (bus.ID_UseRt & (bus.ID_Rt == ex_dst)));
    flush   = bus.EX_BranchTaken;
    bubble  = lu | flush;
    stall   = lu & ~flush;
    fwd_a_d = bubble ? FWD_REG : sel_a;
    fwd_b_d = bubble ? FWD_REG : sel_b;
  end

  // WB is tracked for completeness; the write-first register file makes it select-free.
  assign unused_wb = ^wb_q;

  fwd_select #(.ZeroReg(ZERO_REG)) u_fwd_a (
    .src     (bus.ID_Rs),
    .use_src (bus.ID_Valid & bus.ID_UseRs),
    .ex_rec  (ex_q),
    .mem_rec (mem_q),
    .sel     (sel_a)
  );

  fwd_select #(.ZeroReg(ZERO_REG)) u_fwd_b (
    .src     (bus.ID_Rt),
    .use_src (bus.ID_Valid & bus.ID_UseRt),
    .ex_rec  (ex_q),
    .mem_rec (mem_q),
    .sel     (sel_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= bubble ? '0 : id_rec;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.ForwardA    = fwd_a_q;
  assign bus.ForwardB    = fwd_b_q;
  assign bus.Stall       = stall;
  assign bus.IDEX_Bubble = bubble;
  assign bus.IFID_Flush  = flush;

`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt_q, exmem_cnt_q, memwb_cnt_q;
  logic [1:0]  exmem_inc, memwb_inc;

  always_comb begin
    exmem_inc = {1'b0, fwd_a_d == FWD_EXMEM} + {1'b0, fwd_b_d == FWD_EXMEM};
    memwb_inc = {1'b0, fwd_a_d == FWD_MEMWB} + {1'b0, fwd_b_d == FWD_MEMWB};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      exmem_cnt_q <= '0;
      memwb_cnt_q <= '0;
    end else begin
      stall_cnt_q <= sat_add(stall_cnt_q, {1'b0, stall});
      exmem_cnt_q <= sat_add(exmem_cnt_q, exmem_inc);
      memwb_cnt_q <= sat_add(memwb_cnt_q, memwb_inc);
    end
  end

  assign bus.StallCnt    = stall_cnt_q;
  assign bus.FwdExMemCnt = exmem_cnt_q;
  assign bus.FwdMemWbCnt = memwb_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_forward_ctrl.sv
// Bench for pipeline_forward_ctrl: instruction-history model plus directed literal checks.
module tb_pipeline_forward_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipeline_forward_ctrl_if #(.REG_AW(5)) bus ();

  pipeline_forward_ctrl #(.REG_AW(5), .ZERO_REG(5'd0)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the list of instructions that entered EX, newest last. An ID instruction in
  // flight one slot behind a producer gets 10, two slots behind gets 01.
  typedef struct {bit v; int dst; bit rw; bit mr;} ins_t;
  ins_t hist[$];
  ins_t nil_ins = '{v: 0, dst: 0, rw: 0, mr: 0};
  logic [1:0] exp_fa, exp_fb;

  function automatic bit writes(ins_t i, int r);
    return i.v && i.rw && i.dst == r && r != 0;
  endfunction

  function automatic logic [1:0] exp_sel(int r, bit used);
    if (!used || !bus.ID_Valid) return 2'b00;
    for (int age = 1; age <= 2; age++) begin
      if (writes(hist[hist.size() - age], r)) return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic bit exp_lu();
    ins_t e;
    e = hist[hist.size() - 1];
    if (!bus.ID_Valid || !e.mr || !writes(e, int'(e.dst))) return 1'b0;
    return (bus.ID_UseRs && int'(bus.ID_Rs) == e.dst) || (bus.ID_UseRt && int'(bus.ID_Rt) == e.dst);
  endfunction

  function automatic bit exp_bubble();
    return exp_lu() || bus.EX_BranchTaken;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      repeat (3) hist.push_back(nil_ins);
      exp_fa <= 2'b00;
      exp_fb <= 2'b00;
    end else begin
      exp_fa <= exp_bubble() ? 2'b00 : exp_sel(int'(bus.ID_Rs), bus.ID_UseRs);
      exp_fb <= exp_bubble() ? 2'b00 : exp_sel(int'(bus.ID_Rt), bus.ID_UseRt);
      if (exp_bubble()) hist.push_back(nil_ins);
      else hist.push_back('{v: bus.ID_Valid, dst: int'(bus.ID_Dst), rw: bus.ID_RegWrite,
                            mr: bus.ID_MemRead});
      void'(hist.pop_front());
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("model ForwardA", bus.ForwardA, exp_fa);
    chk("model ForwardB", bus.ForwardB, exp_fb);
    chk("model Stall", {1'b0, bus.Stall}, {1'b0, exp_lu() && !bus.EX_BranchTaken});
    chk("model IDEX_Bubble", {1'b0, bus.IDEX_Bubble}, {1'b0, exp_bubble()});
    chk("model IFID_Flush", {1'b0, bus.IFID_Flush}, {1'b0, bus.EX_BranchTaken});
  end

  logic s_stall, s_bubble, s_flush;

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int dst, input bit rw, input bit mr, input bit br);
    bus.ID_Valid       = v;
    bus.ID_Rs          = 5'(rs);
    bus.ID_Rt          = 5'(rt);
    bus.ID_UseRs       = urs;
    bus.ID_UseRt       = urt;
    bus.ID_Dst         = 5'(dst);
    bus.ID_RegWrite    = rw;
    bus.ID_MemRead     = mr;
    bus.EX_BranchTaken = br;
  endtask

  // Present one ID instruction for a cycle; returns just after the edge, with it in EX.
  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input int dst, input bit rw, input bit mr, input bit br);
    drive(v, rs, rt, urs, urt, dst, rw, mr, br);
    #2;
    s_stall  = bus.Stall;
    s_bubble = bus.IDEX_Bubble;
    s_flush  = bus.IFID_Flush;
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input int dst, input int rs, input int rt);
    step(1, rs, rt, 1, 1, dst, 1, 0, 0);
  endtask

  task automatic lw(input int dst, input int base);
    step(1, base, dst, 1, 0, dst, 1, 1, 0);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ForwardA", bus.ForwardA, 2'b00);
    chk("reset ForwardB", bus.ForwardB, 2'b00);
    chk("reset Stall", {1'b0, bus.Stall}, 2'b00);
    chk("reset Bubble", {1'b0, bus.IDEX_Bubble}, 2'b00);
    rst_n = 1'b1;

    // EX/MEM forward back-to-back
    alu(3, 1, 2);
    alu(4, 3, 5);
    chk("exmem fa", bus.ForwardA, 2'b10);
    chk("exmem fb", bus.ForwardB, 2'b00);
    chk("exmem stall", {1'b0, s_stall}, 2'b00);

    // MEM/WB forward across a nop
    alu(3, 1, 2);
    nop();
    alu(6, 7, 3);
    chk("memwb fa", bus.ForwardA, 2'b00);
    chk("memwb fb", bus.ForwardB, 2'b01);

    // Load-use: one stall, then 01 on both operands
    lw(8, 1);
    alu(9, 8, 8);
    chk("lu stall", {1'b0, s_stall}, 2'b01);
    chk("lu bubble", {1'b0, s_bubble}, 2'b01);
    chk("lu bubble fa", bus.ForwardA, 2'b00);
    alu(9, 8, 8);
    chk("lu retry stall", {1'b0, s_stall}, 2'b00);
    chk("lu retry fa", bus.ForwardA, 2'b01);
    chk("lu retry fb", bus.ForwardB, 2'b01);

    // Youngest producer wins; $0 never forwards
    alu(3, 1, 2);
    alu(3, 3, 1);
    alu(10, 3, 0);
    chk("youngest fa", bus.ForwardA, 2'b10);
    chk("zero fb", bus.ForwardB, 2'b00);
    alu(0, 1, 2);
    alu(11, 0, 0);
    chk("zero dst fa", bus.ForwardA, 2'b00);
    chk("zero dst fb", bus.ForwardB, 2'b00);

    // Load-use coinciding with a taken branch
    lw(12, 1);
    step(1, 12, 2, 1, 1, 13, 1, 0, 1);
    chk("flush stall", {1'b0, s_stall}, 2'b00);
    chk("flush iflush", {1'b0, s_flush}, 2'b01);
    chk("flush bubble", {1'b0, s_bubble}, 2'b01);
    chk("flush fa", bus.ForwardA, 2'b00);
    chk("flush fb", bus.ForwardB, 2'b00);

    // Load into $0, and load followed by an independent instruction
    lw(0, 1);
    alu(1, 0, 0);
    chk("lw zero stall", {1'b0, s_stall}, 2'b00);
    chk("lw zero fa", bus.ForwardA, 2'b00);
    lw(14, 1);
    alu(15, 1, 2);
    chk("indep stall", {1'b0, s_stall}, 2'b00);

    // Invalid ID slot: no hazard, no select
    alu(3, 1, 2);
    step(0, 3, 3, 1, 1, 5, 1, 0, 0);
    chk("invalid fa", bus.ForwardA, 2'b00);
    lw(16, 1);
    step(0, 16, 16, 1, 1, 5, 1, 0, 0);
    chk("invalid stall", {1'b0, s_stall}, 2'b00);

    // Reset with producers in flight
    alu(5, 1, 2);
    lw(3, 5);
    chk("pre-reset fa", bus.ForwardA, 2'b10);
    drive(1, 3, 3, 1, 1, 20, 1, 0, 0);
    #2;
    chk("pre-reset stall", {1'b0, bus.Stall}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("mid-reset stall", {1'b0, bus.Stall}, 2'b00);
    chk("mid-reset fa", bus.ForwardA, 2'b00);
    chk("mid-reset bubble", {1'b0, bus.IDEX_Bubble}, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    alu(22, 3, 5);
    chk("post-reset stall", {1'b0, s_stall}, 2'b00);
    chk("post-reset fa", bus.ForwardA, 2'b00);
    chk("post-reset fb", bus.ForwardB, 2'b00);

    nop();
    nop();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
